// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the system memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 20;
  localparam int unsigned DEF_DATA_W = 8;

  // Every access walks IDLE -> ISSUE -> DONE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  // Requester that currently owns the memory port.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the byte-wide system memory port: 8088 core
// (read/write) and video scan-out (read-only). Video has priority, but a
// starvation counter hands the port to a waiting CPU after MAX_WAIT
// consecutive video grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_out,
  output logic [DATA_W-1:0] cpu_in,
  output logic              cpu_ready,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_address,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_out,
  input  logic [DATA_W-1:0] mem_in
);

  localparam logic [3:0] STARVE_MAX = 4'(MAX_WAIT);

  arb_state_t        r_state;
  arb_owner_t        r_owner;
  logic [3:0]        r_starve_cnt;
  logic [ADDR_W-1:0] r_mem_address;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_out;
  logic [DATA_W-1:0] r_cpu_in;
  logic [DATA_W-1:0] r_vid_data;
  logic              r_cpu_ready;
  logic              r_vid_ready;

  logic              w_starved;
  logic              w_grant_cpu;

  // Grant decision for the IDLE cycle: CPU wins alone or once starved.
  always_comb begin
    w_starved   = (r_starve_cnt == STARVE_MAX);
    w_grant_cpu = cpu_req && (!vid_req || w_starved);
  end

  // Arbitration FSM, starvation counter and registered memory/requester outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_owner       <= OWN_CPU;
      r_starve_cnt  <= '0;
      r_mem_address <= '0;
      r_mem_we      <= 1'b0;
      r_mem_out     <= '0;
      r_cpu_in      <= '0;
      r_vid_data    <= '0;
      r_cpu_ready   <= 1'b0;
      r_vid_ready   <= 1'b0;
    end else begin
      r_cpu_ready <= 1'b0;
      r_vid_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_req || vid_req) begin
            r_mem_out <= cpu_out;
            r_state   <= ISSUE;
            if (w_grant_cpu) begin
              r_owner       <= OWN_CPU;
              r_mem_address <= cpu_address;
              r_mem_we      <= cpu_we;
              r_starve_cnt  <= '0;
            end else begin
              r_owner       <= OWN_VID;
              r_mem_address <= vid_address;
              r_mem_we      <= 1'b0;
              if (cpu_req && !w_starved)
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
          end
        end
        ISSUE: begin
          // mem_in already reflects the address registered at grant, so the
          // read result is captured here and appears together with ready.
          r_mem_we <= 1'b0;
          r_state  <= DONE;
          if (r_owner == OWN_CPU) begin
            r_cpu_ready <= 1'b1;
            if (!r_mem_we)
              r_cpu_in <= mem_in;
          end else begin
            r_vid_ready <= 1'b1;
            r_vid_data  <= mem_in;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_address = r_mem_address;
  assign mem_we      = r_mem_we;
  assign mem_out     = r_mem_out;
  assign cpu_in      = r_cpu_in;
  assign vid_data    = r_vid_data;
  // Ready is gated so a reset arriving during DONE suppresses the pulse.
  assign cpu_ready   = r_cpu_ready && !reset;
  assign vid_ready   = r_vid_ready && !reset;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple memory model attached.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clock;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_out;
  logic [7:0]  cpu_in;
  logic        cpu_ready;
  logic        vid_req;
  logic [19:0] vid_address;
  logic [7:0]  vid_data;
  logic        vid_ready;
  logic [19:0] mem_address;
  logic        mem_we;
  logic [7:0]  mem_out;
  logic [7:0]  mem_in;

  int vectors;
  int fails;

  int we_cnt;
  int cpu_rdy_cnt;
  int vid_rdy_cnt;
  int both_cnt;

  logic        pre_we;
  logic [19:0] pre_a;
  logic [7:0]  pre_d;
  logic [7:0]  mem [0:(1<<20)-1];

  mem_arbiter #(.ADDR_W(20), .DATA_W(8), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address),
    .cpu_out(cpu_out), .cpu_in(cpu_in), .cpu_ready(cpu_ready),
    .vid_req(vid_req), .vid_address(vid_address), .vid_data(vid_data),
    .vid_ready(vid_ready),
    .mem_address(mem_address), .mem_we(mem_we), .mem_out(mem_out),
    .mem_in(mem_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory: address register lives in the arbiter, read is combinational on it,
  // write commits at the posedge while mem_we is high (independent of reset).
  assign mem_in = mem[mem_address];
  always @(posedge clock) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (mem_we) mem[mem_address] <= mem_out;
  end

  always @(negedge clock) begin
    if (mem_we) we_cnt++;
    if (cpu_ready) cpu_rdy_cnt++;
    if (vid_ready) vid_rdy_cnt++;
    if (cpu_ready && vid_ready) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // CPU access; cyc counts the cycle the request is first seen as 1, 0 on timeout.
  task automatic cpu_access(input logic we, input logic [19:0] a, input logic [7:0] d,
                            output int cyc, output logic cwe, output logic [19:0] ca,
                            output logic [7:0] cd);
    int c;
    cpu_req = 1'b1; cpu_we = we; cpu_address = a; cpu_out = d;
    cyc = 0; c = 1; cwe = 1'bx; ca = 'x; cd = 'x;
    for (int k = 0; k < 40; k++) begin
      tick();
      c++;
      if (c == 2) begin cwe = mem_we; ca = mem_address; cd = mem_out; end
      if (cpu_ready) begin cyc = c; break; end
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    int cyc, cv, cc, nv, w0, rc0, rv0;
    logic cwe;
    logic [19:0] ca, a0;
    logic [7:0] cd;

    vectors = 0; fails = 0;
    we_cnt = 0; cpu_rdy_cnt = 0; vid_rdy_cnt = 0; both_cnt = 0;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_out = '0;
    vid_req = 1'b0; vid_address = '0;
    pre_we = 1'b1; pre_a = 20'hFF000; pre_d = 8'hEA;
    tick();
    pre_a = 20'h0B800; pre_d = 8'hC3;
    tick();
    pre_we = 1'b0;
    tick();

    // Reset state
    chk("rst_mem_address", 32'(mem_address), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_out", 32'(mem_out), 32'h0);
    chk("rst_cpu_in", 32'(cpu_in), 32'h0);
    chk("rst_vid_data", 32'(vid_data), 32'h0);
    chk("rst_readies", {30'h0, cpu_ready, vid_ready}, 32'h0);
    chk("rst_starve", 32'(dut.r_starve_cnt), 32'h0);
    reset = 1'b0;
    tick();

    // CPU read only
    rv0 = vid_rdy_cnt;
    cpu_access(1'b0, 20'hFF000, 8'h00, cyc, cwe, ca, cd);
    chk("rd_latency", 32'(cyc), 32'd3);
    chk("rd_cpu_in", 32'(cpu_in), 32'hEA);
    chk("rd_issue_addr", 32'(ca), 32'hFF000);
    chk("rd_no_vid_ready", 32'(vid_rdy_cnt - rv0), 32'd0);
    tick(); tick();
    chk("rd_cpu_in_held", 32'(cpu_in), 32'hEA);

    // CPU write then read
    w0 = we_cnt;
    cpu_access(1'b1, 20'h00400, 8'h5A, cyc, cwe, ca, cd);
    chk("wr_latency", 32'(cyc), 32'd3);
    chk("wr_issue_we", 32'(cwe), 32'h1);
    chk("wr_issue_addr", 32'(ca), 32'h00400);
    chk("wr_issue_data", 32'(cd), 32'h5A);
    chk("wr_cpu_in_unchanged", 32'(cpu_in), 32'hEA);
    tick();
    chk("wr_we_cycles", 32'(we_cnt - w0), 32'd1);
    chk("wr_mem_content", 32'(mem[20'h00400]), 32'h5A);
    cpu_access(1'b0, 20'h00400, 8'h00, cyc, cwe, ca, cd);
    chk("wr_rd_latency", 32'(cyc), 32'd3);
    chk("wr_rd_cpu_in", 32'(cpu_in), 32'h5A);
    tick();

    // Simultaneous requests: video first, then CPU
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 20'hFF000;
    vid_req = 1'b1; vid_address = 20'h0B800;
    cv = 0; cc = 0; cyc = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      cyc++;
      if (vid_ready) begin cv = cyc; vid_req = 1'b0; end
      if (cpu_ready) begin cc = cyc; cpu_req = 1'b0; break; end
    end
    chk("sim_vid_cycle", 32'(cv), 32'd3);
    chk("sim_cpu_cycle", 32'(cc), 32'd6);
    chk("sim_vid_data", 32'(vid_data), 32'hC3);
    chk("sim_cpu_in", 32'(cpu_in), 32'hEA);
    chk("sim_starve_cleared", 32'(dut.r_starve_cnt), 32'h0);
    tick();

    // Starvation limit: video held continuously
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 20'h00400;
    vid_req = 1'b1; vid_address = 20'h0B800;
    nv = 0; cc = 0; cyc = 1;
    for (int k = 0; k < 60; k++) begin
      tick();
      cyc++;
      if (vid_ready) nv++;
      if (cyc == 12) chk("stv_cnt_saturated", 32'(dut.r_starve_cnt), 32'd4);
      if (cpu_ready) begin cc = cyc; break; end
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    chk("stv_vid_pulses", 32'(nv), 32'd4);
    chk("stv_cpu_latency", 32'(cc), 32'd15);
    chk("stv_cpu_in", 32'(cpu_in), 32'h5A);
    chk("stv_starve_zero", 32'(dut.r_starve_cnt), 32'h0);
    tick();

    // Video-only grant leaves the counter alone
    vid_req = 1'b1; vid_address = 20'hFF000;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (vid_ready) break;
    end
    vid_req = 1'b0;
    chk("vid_only_data", 32'(vid_data), 32'hEA);
    chk("vid_only_starve", 32'(dut.r_starve_cnt), 32'h0);
    tick();

    // Reset during ISSUE of a write to the top address
    rc0 = cpu_rdy_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_address = 20'hFFFFF; cpu_out = 8'h33;
    tick();
    chk("rsti_issue_we", 32'(mem_we), 32'h1);
    reset = 1'b1;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("rsti_mem_commit", 32'(mem[20'hFFFFF]), 32'h33);
    chk("rsti_outputs_zero", {4'h0, mem_address, mem_we, cpu_ready, vid_ready, 1'b0, 4'h0},
        32'h0);
    chk("rsti_data_zero", {16'h0, cpu_in, vid_data}, 32'h0);
    chk("rsti_mem_out_zero", 32'(mem_out), 32'h0);
    chk("rsti_state_idle", 32'(dut.r_state), 32'(IDLE));
    reset = 1'b0;
    tick();
    chk("rsti_no_ready", 32'(cpu_rdy_cnt - rc0), 32'd0);
    cpu_access(1'b0, 20'hFFFFF, 8'h00, cyc, cwe, ca, cd);
    chk("rsti_readback", 32'(cpu_in), 32'h33);
    tick();

    // Reset during DONE suppresses the ready pulse
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 20'hFF000;
    tick();
    tick();
    chk("rstd_ready_in_done", 32'(cpu_ready), 32'h1);
    reset = 1'b1;
    #1;
    chk("rstd_ready_suppressed", 32'(cpu_ready), 32'h0);
    tick();
    cpu_req = 1'b0;
    reset = 1'b0;
    chk("rstd_state_idle", 32'(dut.r_state), 32'(IDLE));
    tick();

    // Load a known address, then idle for 20 cycles
    cpu_access(1'b0, 20'h12345, 8'h00, cyc, cwe, ca, cd);
    tick();
    a0 = mem_address; w0 = we_cnt; rc0 = cpu_rdy_cnt; rv0 = vid_rdy_cnt;
    for (int k = 0; k < 20; k++) tick();
    chk("idle_addr_held", 32'(mem_address), 32'h12345);
    chk("idle_addr_stable", 32'(mem_address), 32'(a0));
    chk("idle_no_we", 32'(we_cnt - w0), 32'd0);
    chk("idle_no_ready", 32'((cpu_rdy_cnt - rc0) + (vid_rdy_cnt - rv0)), 32'd0);
    chk("never_both_ready", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
